freepdk45_sram_ctrl_64x40: RTL and testbench

// - Host-side initiator for freepdk45_sram_1rw0r_64x40_20: turns valid/ready read/write requests into

---
 rtl/freepdk45_sram_ctrl_pkg.sv | 15 +
 rtl/freepdk45_sram_rsp_fifo.sv | 48 ++++
 rtl/freepdk45_sram_ctrl_64x40.sv | 110 +++++++++++
 tb/tb_freepdk45_sram_ctrl_64x40.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/freepdk45_sram_ctrl_pkg.sv
// freepdk45_sram_ctrl_pkg: shared widths, FSM state and request bundle for the 64x40 SRAM controller
package freepdk45_sram_ctrl_pkg;
  localparam int DEF_DATA_WIDTH = 40;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_NUM_WMASKS = 2;
  localparam int DEF_RSP_DEPTH  = 4;
  localparam int LANE_WIDTH     = DEF_DATA_WIDTH / DEF_NUM_WMASKS;
  typedef enum logic {ST_INIT, ST_RUN} ctrl_state_e;
  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_NUM_WMASKS-1:0] wmask;
    logic [DEF_DATA_WIDTH-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/freepdk45_sram_rsp_fifo.sv
// freepdk45_sram_rsp_fifo: show-ahead read-response FIFO; output holds the last popped word while empty
module freepdk45_sram_rsp_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          do_pop;
  assign valid  = cnt_q != '0;
  assign do_pop = pop & valid;
  assign count  = cnt_q;
  assign rdata  = valid ? mem_q[rd_q] : hold_q;
  always_comb begin
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + CW'(push) - CW'(do_pop);
    hold_d = do_pop ? mem_q[rd_q] : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end
endmodule

// File: rtl/freepdk45_sram_ctrl_64x40.sv
// freepdk45_sram_ctrl_64x40: zero-fills the 64x40 macro after reset, then issues one host op per clock
module freepdk45_sram_ctrl_64x40
  import freepdk45_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;
  ctrl_state_e           state_q, state_d;
  sram_req_t             req;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic                  csb_q, csb_d, web_q, web_d;
  logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [1:0]            infl_q, infl_d;
  logic [CW-1:0]         fifo_count;
  logic                  accept, credit;
  assign req         = '{write: req_write, addr: req_addr, wmask: req_wmask, wdata: req_wdata};
  // Both in-flight stages reserve a FIFO slot, so a push can never find the FIFO full
  assign credit      = (32'(fifo_count) + 32'(infl_q[0]) + 32'(infl_q[1])) < 32'(RSP_DEPTH);
  assign req_ready   = ~rst0 & (state_q == ST_RUN) & credit;
  assign accept      = req_valid & req_ready;
  assign init_done   = state_q == ST_RUN;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;
  always_ff @(posedge clk0) begin
    if (rst0) state_q <= ST_INIT;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == ST_INIT && cnt_q == '1) ? ST_RUN : state_q;
  end
  always_comb begin
    csb_d   = 1'b1;
    web_d   = web_q;
    wmask_d = wmask_q;
    addr_d  = addr_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    infl_d  = {infl_q[0], accept & ~req.write};
    if (state_q == ST_INIT) begin
      csb_d   = 1'b0;
      web_d   = 1'b0;
      wmask_d = '1;
      din_d   = '0;
      addr_d  = cnt_q;
      cnt_d   = cnt_q + ADDR_WIDTH'(1);
    end else if (accept) begin
      csb_d   = 1'b0;
      web_d   = ~req.write;
      wmask_d = req.wmask;
      addr_d  = req.addr;
      din_d   = req.wdata;
    end
  end
  always_ff @(posedge clk0) begin
    if (rst0) begin
      cnt_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      infl_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      infl_q  <= infl_d;
    end
  end
  // Macro dout0 settles after the negedge of the latch cycle; capture it two edges after accept
  freepdk45_sram_rsp_fifo #(.DW(DATA_WIDTH), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk0),
    .rst       (rst0),
    .push      (infl_q[1]),
    .push_data (sram_dout0),
    .pop       (rsp_ready),
    .rdata     (rsp_rdata),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_freepdk45_sram_ctrl_64x40.sv
// tb_freepdk45_sram_ctrl_64x40: directed checks of the controller driving a behavioural 1rw 64x40 macro
module tb_freepdk45_sram_ctrl_64x40;
  import freepdk45_sram_ctrl_pkg::*;
  logic        clk0 = 1'b0;
  logic        rst0;
  logic        req_valid, req_ready, req_write;
  logic [5:0]  req_addr;
  logic [1:0]  req_wmask;
  logic [39:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [39:0] rsp_rdata;
  logic        init_done;
  logic        sram_csb0, sram_web0;
  logic [1:0]  sram_wmask0;
  logic [5:0]  sram_addr0;
  logic [39:0] sram_din0, sram_dout0;
  int checks = 0;
  int errors = 0;
  always #5 clk0 = ~clk0;
  freepdk45_sram_ctrl_64x40 dut (
    .clk0(clk0), .rst0(rst0),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );
  // Macro model: pins latched at posedge, write or read performed at the following negedge
  logic [39:0] mem [64];
  logic        m_csb, m_web;
  logic [1:0]  m_wm;
  logic [5:0]  m_a;
  logic [39:0] m_d;
  always @(posedge clk0) begin
    m_csb <= sram_csb0;
    m_web <= sram_web0;
    m_wm  <= sram_wmask0;
    m_a   <= sram_addr0;
    m_d   <= sram_din0;
  end
  always @(negedge clk0) begin
    if (m_csb === 1'b0 && m_web === 1'b0) begin
      if (m_wm[0]) mem[m_a][LANE_WIDTH-1:0]          <= m_d[LANE_WIDTH-1:0];
      if (m_wm[1]) mem[m_a][39:LANE_WIDTH]           <= m_d[39:LANE_WIDTH];
    end else if (m_csb === 1'b0) begin
      sram_dout0 <= mem[m_a];
    end
  end
  function automatic logic [39:0] data_of(input int i);
    return {20'hC0DE0 + 20'(i), 20'h0F000 + 20'(i)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk0);
    #1;
  endtask
  task automatic do_write(input logic [5:0] a, input logic [1:0] m, input logic [39:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wmask = m; req_wdata = d;
    chk("wr_ready", req_ready, 1);
    tick;
    chk("wr_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b0, m, a});
    chk("wr_din", sram_din0, d);
    req_valid = 1'b0;
  endtask
  task automatic do_read(input string tag, input logic [5:0] a, input logic [39:0] exp);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    chk({tag, "_ready"}, req_ready, 1);
    tick;
    req_valid = 1'b0;
    chk({tag, "_pins"}, {sram_csb0, sram_web0, sram_addr0}, {1'b0, 1'b1, a});
    tick;
    chk({tag, "_lat1"}, rsp_valid, 0);
    tick;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_rdata, exp);
    tick;
    chk({tag, "_drain"}, rsp_valid, 0);
  endtask
  initial begin
    int nwr, nacc, nrsp, stale;
    logic acc;
    rst0 = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wmask = '0;
    req_wdata = '0; rsp_ready = 1'b1;
    tick; tick;
    chk("rst_pins", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b1, 1'b1, 2'b00, 6'd0});
    chk("rst_din", sram_din0, 0);
    chk("rst_hs", {req_ready, rsp_valid, init_done}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst0 = 1'b0;
    nwr = 0;
    for (int c = 0; c < 100 && !init_done; c++) begin
      tick;
      if (sram_csb0 === 1'b0 && sram_web0 === 1'b0) nwr++;
      if (req_ready !== 1'b0 && !init_done) chk("init_ready", req_ready, 0);
    end
    chk("init_done", init_done, 1);
    chk("init_writes", nwr, 64);
    chk("init_last_addr", sram_addr0, 6'h3F);
    chk("run_ready", req_ready, 1);
    do_read("rd3f", 6'h3F, 40'h0);
    tick;
    chk("idle_csb", sram_csb0, 1);
    chk("idle_addr_hold", sram_addr0, 6'h3F);
    do_write(6'd5, 2'b11, 40'hABCDE12345);
    do_read("raw5", 6'd5, 40'hABCDE12345);
    do_write(6'd9, 2'b01, 40'hFFFFFFFFFF);
    do_read("mask9", 6'd9, 40'h00000FFFFF);
    do_write(6'd9, 2'b00, 40'h123456789A);
    do_read("nomask9", 6'd9, 40'h00000FFFFF);
    for (int i = 0; i < 8; i++) do_write(6'(i), 2'b11, data_of(i));
    rsp_ready = 1'b0; req_write = 1'b0; nacc = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_addr = 6'(nacc);
      acc = req_ready;
      tick;
      if (acc) nacc++;
    end
    chk("bp_accepts", nacc, 4);
    chk("bp_ready", req_ready, 0);
    chk("bp_valid", rsp_valid, 1);
    chk("bp_head", rsp_rdata, data_of(0));
    rsp_ready = 1'b1; nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 8; c++) begin
      if (rsp_valid) begin
        chk("bp_data", rsp_rdata, data_of(nrsp));
        nrsp++;
      end
      req_valid = nacc < 8; req_addr = 6'(nacc);
      acc = req_valid && req_ready;
      tick;
      if (acc) nacc++;
    end
    req_valid = 1'b0;
    chk("bp_rsp_count", nrsp, 8);
    chk("bp_acc_count", nacc, 8);
    tick;
    chk("bp_no_dup", rsp_valid, 0);
    req_valid = 1'b1; req_write = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      req_addr = 6'(i);
      chk("b2b_ready", req_ready, 1);
      tick;
    end
    req_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      chk("b2b_valid", rsp_valid, 1);
      chk("b2b_data", rsp_rdata, data_of(i));
      tick;
    end
    chk("b2b_end", rsp_valid, 0);
    rsp_ready = 1'b0; req_valid = 1'b1; req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_addr = 6'(i);
      tick;
    end
    req_valid = 1'b0;
    chk("mid_fifo", rsp_valid, 1);
    chk("mid_ready_pre", req_ready, 1);
    rst0 = 1'b1;
    #1;
    chk("mid_ready_rst", req_ready, 0);
    tick;
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_csb", sram_csb0, 1);
    tick;
    rst0 = 1'b0; rsp_ready = 1'b1;
    tick;
    chk("reinit_pins", {sram_csb0, sram_web0, sram_addr0}, {1'b0, 1'b0, 6'd0});
    stale = 0;
    for (int c = 0; c < 100 && !init_done; c++) begin
      if (rsp_valid) stale++;
      tick;
    end
    chk("reinit_done", init_done, 1);
    chk("reinit_stale", stale, 0);
    do_read("clr0", 6'd0, 40'h0);
    do_read("clr5", 6'd5, 40'h0);
    do_read("clr7", 6'd7, 40'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
